// File: rtl/fsm_sched_pkg.sv
// Shared types for the context-switched FSM scheduler: state encoding and width.
package fsm_sched_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_A = 3'b000,
        ST_B = 3'b001,
        ST_C = 3'b010,
        ST_D = 3'b011,
        ST_E = 3'b100,
        ST_F = 3'b101
    } state_t;

    localparam state_t ST_RESET = ST_A;

endpackage

// File: rtl/fsm_step.sv
// Combinational Mealy step core: (state, x) -> (next state, z). Shared by all channels.
module fsm_step
    import fsm_sched_pkg::*;
(
    input  logic [ST_W-1:0] state_i,
    input  logic            x_i,
    output state_t          next_o,
    output logic            z_o
);

    always_comb begin
        next_o = ST_A;
        z_o    = 1'b0;
        unique case (state_i)
            ST_A: begin next_o = x_i ? ST_D : ST_E; z_o = x_i;  end
            ST_B: begin next_o = x_i ? ST_D : ST_F; z_o = 1'b0; end
            ST_C: begin next_o = x_i ? ST_B : ST_E; z_o = x_i;  end
            ST_D: begin next_o = x_i ? ST_B : ST_F; z_o = 1'b0; end
            ST_E: begin next_o = x_i ? ST_F : ST_C; z_o = x_i;  end
            ST_F: begin next_o = x_i ? ST_C : ST_B; z_o = 1'b0; end
            // Unused encodings recover to A with no output.
            default: begin next_o = ST_A; z_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/fsm_ctx_scheduler.sv
// Round-robin scheduler sharing one fsm_step core across NCH serial requesters.
// Optional per-channel Z=1 hit counters when FSM_CTX_SCHED_HITCNT_EN is defined.
module fsm_ctx_scheduler
    import fsm_sched_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req_valid,
    input  logic [NCH-1:0]  req_x,
    output logic [NCH-1:0]  req_ready,
    input  logic            clr_valid,
    input  logic [CHW-1:0]  clr_ch,
`ifdef FSM_CTX_SCHED_HITCNT_EN
    input  logic [CHW-1:0]  cnt_sel,
    output logic [15:0]     cnt_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CHW-1:0]  out_ch,
    output logic            out_z,
    output logic [ST_W-1:0] out_state
);

    state_t          ctx_q [NCH];
    logic [CHW-1:0]  prio_q, prio_d;
    logic            out_valid_q;
    logic [CHW-1:0]  out_ch_q;
    logic            out_z_q;
    state_t          out_state_q;

    logic [NCH-1:0]  elig;
    logic            found;
    logic [CHW-1:0]  grant_idx;
    logic            out_free;
    logic            xfer;
    state_t          step_next;
    logic            step_z;
    logic            clr_hit;

    assign clr_hit = clr_valid && (32'(clr_ch) < NCH);

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            elig[i] = req_valid[i] & ~(clr_valid & (clr_ch == CHW'(i)));
        end
    end

    // Scan from prio upward with wrap; first eligible channel wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!found && elig[(32'(prio_q) + k) % NCH]) begin
                found     = 1'b1;
                grant_idx = CHW'((32'(prio_q) + k) % NCH);
            end
        end
    end

    // rst_n gates the grant so req_ready stays low throughout reset.
    assign out_free  = ~out_valid_q | out_ready;
    assign xfer      = found & out_free & rst_n;
    assign req_ready = xfer ? (NCH'(1) << grant_idx) : '0;

    fsm_step u_step (
        .state_i (ctx_q[grant_idx]),
        .x_i     (req_x[grant_idx]),
        .next_o  (step_next),
        .z_o     (step_z)
    );

    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + CHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) ctx_q[i] <= ST_RESET;
            prio_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_z_q     <= 1'b0;
            out_state_q <= ST_RESET;
        end else begin
            prio_q <= prio_d;
            if (xfer) ctx_q[grant_idx] <= step_next;
            if (clr_hit) ctx_q[clr_ch] <= ST_RESET;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= grant_idx;
                out_z_q     <= step_z;
                out_state_q <= step_next;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_z     = out_z_q;
    assign out_state = out_state_q;

`ifdef FSM_CTX_SCHED_HITCNT_EN
    logic [15:0] cnt_q [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            if (xfer && step_z && (cnt_q[grant_idx] != '1)) begin
                cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
            end
            if (clr_hit) cnt_q[clr_ch] <= '0;
        end
    end

    assign cnt_data = (32'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_fsm_ctx_scheduler.sv
// Directed self-checking bench for fsm_ctx_scheduler (default build, NCH = 4).
module tb_fsm_ctx_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_x;
    logic [NCH-1:0] req_ready;
    logic           clr_valid;
    logic [CHW-1:0] clr_ch;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic           out_z;
    logic [2:0]     out_state;

    int checks = 0;
    int errors = 0;

    fsm_ctx_scheduler #(.NCH(NCH), .CHW(CHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .clr_valid (clr_valid),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_z     (out_z),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_x = '0; clr_valid = 1'b0; clr_ch = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; req_x = '1; clr_valid = 1'b0; clr_ch = '0; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({out_ch, out_z, out_state} !== 6'b0) begin errors++; $display("FAIL reset_out_fields got %b want 000000", {out_ch, out_z, out_state}); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready2 got %b want 0000", req_ready); end
        req_valid = '0; req_x = '0;
        rst_n = 1'b1; #1;
    endtask

    task automatic test_single_ch0();
        logic [2:0] xs [3] = '{1'b1, 1'b1, 1'b0};
        logic       ez [3] = '{1'b1, 1'b0, 1'b0};
        logic [2:0] es [3] = '{3'd3, 3'd1, 3'd5};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001; req_x = {3'b000, xs[i][0]}; #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ch0_ready[%0d] got %b want 0001", i, req_ready); end
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'd0, ez[i], es[i]}) begin
                errors++; $display("FAIL ch0_step[%0d] got v=%b ch=%0d z=%b st=%0d want v=1 ch=0 z=%b st=%0d",
                                   i, out_valid, out_ch, out_z, out_state, ez[i], es[i]);
            end
        end
        req_valid = '0; #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ch0_drain got %b want 0", out_valid); end
    endtask

    // Covers rotation order, full throughput, then an output stall and resume.
    task automatic test_round_robin_stall();
        do_reset();
        req_valid = 4'b1111; req_x = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'(k % 4), 1'b0, (k < 4) ? 3'd4 : 3'd2}) begin
                errors++; $display("FAIL rr_out[%0d] got v=%b ch=%0d z=%b st=%0d want v=1 ch=%0d z=0 st=%0d",
                                   k, out_valid, out_ch, out_z, out_state, k % 4, (k < 4) ? 4 : 2);
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); end
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'd1, 1'b0, 3'd2}) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b ch=%0d z=%b st=%0d want v=1 ch=1 z=0 st=2",
                                   k, out_valid, out_ch, out_z, out_state);
            end
        end
        out_ready = 1'b1; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL resume_ready got %b want 0100", req_ready); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'd2, 1'b0, 3'd2}) begin
            errors++; $display("FAIL resume_out got v=%b ch=%0d z=%b st=%0d want v=1 ch=2 z=0 st=2", out_valid, out_ch, out_z, out_state);
        end
        req_valid = '0; #1;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        do_reset();
        req_valid = 4'b0100; req_x = 4'b0000; #1;
        @(posedge clk); #1;
        checks++; if (out_state !== 3'd4) begin errors++; $display("FAIL clr_setup got st=%0d want 4", out_state); end
        clr_valid = 1'b1; clr_ch = 2'd2; req_x = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_block got %b want 0000", req_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_no_output got %b want 0", out_valid); end
        clr_valid = 1'b0; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL clr_retry_ready got %b want 0100", req_ready); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'd2, 1'b1, 3'd3}) begin
            errors++; $display("FAIL clr_retry_out got v=%b ch=%0d z=%b st=%0d want v=1 ch=2 z=1 st=3", out_valid, out_ch, out_z, out_state);
        end
        req_valid = '0; req_x = '0; #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req_valid = 4'b0010; req_x = 4'b0000; #1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({out_valid, out_state} !== {1'b1, 3'd2}) begin errors++; $display("FAIL mid_setup got v=%b st=%0d want v=1 st=2", out_valid, out_state); end
        req_valid = '0; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        checks++; if (out_state !== 3'd0) begin errors++; $display("FAIL mid_async_state got %0d want 0", out_state); end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 4'b0010; req_x = 4'b0010; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready got %b want 0010", req_ready); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_ch, out_z, out_state} !== {1'b1, 2'd1, 1'b1, 3'd3}) begin
            errors++; $display("FAIL mid_after got v=%b ch=%0d z=%b st=%0d want v=1 ch=1 z=1 st=3", out_valid, out_ch, out_z, out_state);
        end
        req_valid = '0; req_x = '0; #1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_round_robin_stall();
        test_clear();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
